gray_conv_arbiter: RTL

GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

---
 rtl/gray_conv_arbiter_if.sv | 22 ++
 rtl/gray_conv_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter_if.sv
// Handshake bundle between four conversion requesters and the shared Gray-code converter.
// The master side is the requester/consumer environment; the slave side is the arbiter.
interface gray_conv_arbiter_if;
  logic [3:0]  req;
  logic [15:0] data_in;
  logic [3:0]  mode;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [3:0]  out_data;

  modport master (
    output req, data_in, mode, out_ready,
    input  gnt, out_valid, out_id, out_data
  );

  modport slave (
    input  req, data_in, mode, out_ready,
    output gnt, out_valid, out_id, out_data
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one 4-bit binary/Gray converter among four requesters.
// Define GRAY_CONV_G2B_EN to compile in the Gray-to-binary direction selected by mode.
module gray_conv_arbiter (
  input  logic                clk,
  input  logic                rst,
  gray_conv_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  gnt_q, gnt_d;
  logic        out_valid_q, out_valid_d;
  logic [1:0]  out_id_q, out_id_d;
  logic [3:0]  out_data_q, out_data_d;

  logic [1:0]  win;
  logic        win_found;
  logic [3:0]  nibble;
  logic [3:0]  conv_result;

  function automatic logic [3:0] bin_to_gray(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

`ifdef GRAY_CONV_G2B_EN
  function automatic logic [3:0] gray_to_bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction
`endif

  // First set request at or above the pointer, wrapping modulo 4.
  always_comb begin
    logic [1:0] idx;
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!win_found && bus.req[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  assign nibble = bus.data_in[{win, 2'b00} +: 4];

`ifdef GRAY_CONV_G2B_EN
  assign conv_result = bus.mode[win] ? gray_to_bin(nibble) : bin_to_gray(nibble);
`else
  logic unused_mode;
  assign unused_mode = ^bus.mode;
  assign conv_result = bin_to_gray(nibble);
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d       = 4'b0001 << win;
          out_id_d    = win;
          out_data_d  = conv_result;
          out_valid_d = 1'b1;
          ptr_d       = win + 2'd1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        // Result is frozen until accepted; no grant on the accepting edge.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_data  = out_data_q;

endmodule
